// File: rtl/hub_arbiter.sv
// hub_arbiter: shared repeat-bus arbiter for a three-port hub.
// Grants the bus round-robin to an armed requesting port, watches the owner's
// frame for a clean end, a collision or a jabber overrun, then runs a jam
// burst and/or an inter-frame gap before arbitrating again. All outputs are
// registered.

module hub_arbiter #(
  parameter int JAM_CYCLES = 4,
  parameter int GAP_CYCLES = 12,
  parameter int MAX_FRAME  = 1518
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] req,
  output logic [2:0] grant,
  output logic       bus_busy,
  output logic       collision,
  output logic       jabber,
  output logic       jam,
  output logic       frame_done
);

  // Byte counter must hold MAX_FRAME itself without wrapping.
  localparam int CNT_W   = $clog2(MAX_FRAME + 1);
  // One timer serves both JAM and GAP; it only needs to reach the longer one minus 1.
  localparam int TMR_MAX = (JAM_CYCLES > GAP_CYCLES) ? JAM_CYCLES : GAP_CYCLES;
  localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_JAM   = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  state_t           state_r, state_next;
  logic [2:0]       grant_r, grant_next;
  logic             bus_busy_r, bus_busy_next;
  logic             collision_r, collision_next;
  logic             jabber_r, jabber_next;
  logic             jam_r, jam_next;
  logic             frame_done_r, frame_done_next;
  logic [CNT_W-1:0] byte_cnt_r, byte_cnt_next;
  logic [TMR_W-1:0] tmr_r, tmr_next;
  logic [1:0]       last_grant_r, last_grant_next;
  logic [2:0]       armed_r, armed_next;

  logic [2:0]       eligible_s;
  logic [2:0]       pick_s;
  logic [2:0]       disarm_s;
  logic             owner_req_s;
  logic             other_req_s;

  // Round-robin pick: search starts at the port after the last granted one.
  function automatic logic [2:0] rr_pick(input logic [2:0] elig, input logic [1:0] last);
    logic [2:0] res;
    res = 3'b000;
    case (last)
      2'd0: begin
        if (elig[1])      res = 3'b010;
        else if (elig[2]) res = 3'b100;
        else if (elig[0]) res = 3'b001;
        else              res = 3'b000;
      end
      2'd1: begin
        if (elig[2])      res = 3'b100;
        else if (elig[0]) res = 3'b001;
        else if (elig[1]) res = 3'b010;
        else              res = 3'b000;
      end
      default: begin
        if (elig[0])      res = 3'b001;
        else if (elig[1]) res = 3'b010;
        else if (elig[2]) res = 3'b100;
        else              res = 3'b000;
      end
    endcase
    return res;
  endfunction

  // One-hot grant to port index (0 = port1).
  function automatic logic [1:0] onehot_idx(input logic [2:0] oh);
    logic [1:0] idx;
    case (oh)
      3'b010:  idx = 2'd1;
      3'b100:  idx = 2'd2;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  assign eligible_s  = armed_r & req;
  assign pick_s      = rr_pick(eligible_s, last_grant_r);
  assign owner_req_s = |(req & grant_r);
  assign other_req_s = |(req & ~grant_r);

  // Next-state, next-output and arming logic for the arbiter FSM.
  always_comb begin
    state_next      = state_r;
    grant_next      = grant_r;
    bus_busy_next   = bus_busy_r;
    collision_next  = 1'b0;
    jabber_next     = 1'b0;
    jam_next        = jam_r;
    frame_done_next = 1'b0;
    byte_cnt_next   = byte_cnt_r;
    tmr_next        = tmr_r;
    last_grant_next = last_grant_r;
    disarm_s        = 3'b000;

    case (state_r)
      ST_IDLE: begin
        if (|eligible_s) begin
          grant_next      = pick_s;
          last_grant_next = onehot_idx(pick_s);
          disarm_s        = pick_s;
          byte_cnt_next   = {CNT_W{1'b0}};
          bus_busy_next   = 1'b1;
          state_next      = ST_GRANT;
        end else begin
          grant_next    = 3'b000;
          bus_busy_next = 1'b0;
        end
      end

      ST_GRANT: begin
        if (!owner_req_s) begin
          // Owner dropped: clean end, even if another port rose this cycle.
          frame_done_next = 1'b1;
          grant_next      = 3'b000;
          tmr_next        = {TMR_W{1'b0}};
          state_next      = ST_GAP;
        end else begin
          byte_cnt_next = byte_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          if (byte_cnt_r == CNT_W'(MAX_FRAME - 1)) begin
            // Jabber wins over a simultaneous collision.
            jabber_next = 1'b1;
            grant_next  = 3'b000;
            jam_next    = 1'b1;
            disarm_s    = req;
            tmr_next    = {TMR_W{1'b0}};
            state_next  = ST_JAM;
          end else if (other_req_s) begin
            collision_next = 1'b1;
            grant_next     = 3'b000;
            jam_next       = 1'b1;
            disarm_s       = req;
            tmr_next       = {TMR_W{1'b0}};
            state_next     = ST_JAM;
          end else begin
            state_next = ST_GRANT;
          end
        end
      end

      ST_JAM: begin
        if (tmr_r == TMR_W'(JAM_CYCLES - 1)) begin
          jam_next   = 1'b0;
          tmr_next   = {TMR_W{1'b0}};
          state_next = ST_GAP;
        end else begin
          tmr_next = tmr_r + {{(TMR_W-1){1'b0}}, 1'b1};
        end
      end

      ST_GAP: begin
        if (tmr_r == TMR_W'(GAP_CYCLES - 1)) begin
          bus_busy_next = 1'b0;
          tmr_next      = {TMR_W{1'b0}};
          state_next    = ST_IDLE;
        end else begin
          tmr_next = tmr_r + {{(TMR_W-1){1'b0}}, 1'b1};
        end
      end

      default: begin
        state_next    = ST_IDLE;
        grant_next    = 3'b000;
        bus_busy_next = 1'b0;
        jam_next      = 1'b0;
      end
    endcase

    // A port arms whenever it is seen idle; granting or colliding disarms it.
    armed_next = (armed_r | ~req) & ~disarm_s;
  end

  // State and registered-output flops; reset aborts any frame with no pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= ST_IDLE;
      grant_r      <= 3'b000;
      bus_busy_r   <= 1'b0;
      collision_r  <= 1'b0;
      jabber_r     <= 1'b0;
      jam_r        <= 1'b0;
      frame_done_r <= 1'b0;
      byte_cnt_r   <= {CNT_W{1'b0}};
      tmr_r        <= {TMR_W{1'b0}};
      last_grant_r <= 2'd2;
      armed_r      <= 3'b000;
    end else begin
      state_r      <= state_next;
      grant_r      <= grant_next;
      bus_busy_r   <= bus_busy_next;
      collision_r  <= collision_next;
      jabber_r     <= jabber_next;
      jam_r        <= jam_next;
      frame_done_r <= frame_done_next;
      byte_cnt_r   <= byte_cnt_next;
      tmr_r        <= tmr_next;
      last_grant_r <= last_grant_next;
      armed_r      <= armed_next;
    end
  end

  assign grant      = grant_r;
  assign bus_busy   = bus_busy_r;
  assign collision  = collision_r;
  assign jabber     = jabber_r;
  assign jam        = jam_r;
  assign frame_done = frame_done_r;

endmodule

// File: tb/tb_hub_arbiter.sv
// tb_hub_arbiter: table-driven checks of hub_arbiter with an expectation queue.
// Each table row is one clock: req driven before the edge, outputs expected after it.

module tb_hub_arbiter;

  typedef struct {
    logic [2:0] req;
    logic [2:0] grant;
    logic       busy;
    logic       col;
    logic       jab;
    logic       jm;
    logic       fd;
  } vec_t;

  logic       clk;
  logic       reset;
  logic [2:0] req;
  logic [2:0] grant;
  logic       bus_busy;
  logic       collision;
  logic       jabber;
  logic       jam;
  logic       frame_done;

  vec_t tbl[$];
  vec_t exp_q[$];
  int   compared;
  int   mismatched;

  hub_arbiter #(.JAM_CYCLES(4), .GAP_CYCLES(12), .MAX_FRAME(1518)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .grant      (grant),
    .bus_busy   (bus_busy),
    .collision  (collision),
    .jabber     (jabber),
    .jam        (jam),
    .frame_done (frame_done)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void add(input logic [2:0] r, input logic [2:0] g, input logic b,
                              input logic c, input logic j, input logic jm, input logic f);
    vec_t v;
    v.req = r; v.grant = g; v.busy = b; v.col = c; v.jab = j; v.jm = jm; v.fd = f;
    tbl.push_back(v);
  endfunction

  // Rest of the gap after its first cycle: 11 busy cycles, then back to idle.
  function automatic void add_gap(input logic [2:0] r);
    for (int i = 0; i < 11; i++) add(r, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    add(r, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction

  // Rest of the jam after its first cycle: 3 jam cycles, first gap cycle, rest of gap.
  function automatic void add_jam(input logic [2:0] r);
    for (int i = 0; i < 3; i++) add(r, 3'b000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    add(r, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    add_gap(r);
  endfunction

  task automatic compare(input string name, input int idx);
    vec_t e;
    e = exp_q.pop_front();
    compared++;
    if ({grant, bus_busy, collision, jabber, jam, frame_done} !==
        {e.grant, e.busy, e.col, e.jab, e.jm, e.fd}) begin
      mismatched++;
      $display("FAIL %s row %0d: got grant=%b busy=%b col=%b jab=%b jam=%b fd=%b, expected grant=%b busy=%b col=%b jab=%b jam=%b fd=%b",
               name, idx, grant, bus_busy, collision, jabber, jam, frame_done,
               e.grant, e.busy, e.col, e.jab, e.jm, e.fd);
    end
  endtask

  task automatic push_zero();
    vec_t z;
    z.req = 3'b000; z.grant = 3'b000; z.busy = 1'b0; z.col = 1'b0;
    z.jab = 1'b0; z.jm = 1'b0; z.fd = 1'b0;
    exp_q.push_back(z);
  endtask

  task automatic run_table(input string name);
    for (int i = 0; i < tbl.size(); i++) begin
      req = tbl[i].req;
      exp_q.push_back(tbl[i]);
      @(posedge clk);
      #1;
      compare(name, i);
    end
    tbl.delete();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    req   = 3'b000;
    @(posedge clk);
    #1;
    push_zero();
    compare("reset", 0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    req        = 3'b000;

    // Single-port frame of 13 request cycles, gap timing, idle hold.
    do_reset();
    add(3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    add(3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 13; i++) add(3'b001, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    add(3'b000, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    add_gap(3'b000);
    run_table("single_frame");

    // Round-robin order from reset with all three ports raising together.
    do_reset();
    add(3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int p = 0; p < 3; p++) begin
      logic [2:0] oh;
      oh = 3'b001 << p;
      add(3'b111, oh, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) add(oh, oh, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      add(3'b000, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      add_gap(3'b000);
    end
    run_table("round_robin");

    // Port3 collides with port1 at byte 5; both disarmed until each drops.
    add(3'b001, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) add(3'b001, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    add(3'b101, 3'b000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    add_jam(3'b101);
    for (int i = 0; i < 2; i++) add(3'b101, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) add(3'b001, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    add(3'b100, 3'b100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    add(3'b000, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    add_gap(3'b000);
    add(3'b001, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    add(3'b000, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    add_gap(3'b000);
    run_table("collision");

    // Port2 holds req for 1600 cycles: jabber after 1518 grant cycles, no frame_done.
    for (int i = 0; i < 1518; i++) add(3'b010, 3'b010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    add(3'b010, 3'b000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    add_jam(3'b010);
    for (int i = 0; i < 65; i++) add(3'b010, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    add(3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_table("jabber");

    // Port1 drops as port2 rises: clean end, port2 granted after the gap.
    add(3'b001, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) add(3'b001, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    add(3'b010, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    add_gap(3'b010);
    add(3'b010, 3'b010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    add(3'b000, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    add_gap(3'b000);
    run_table("handover");

    // Drive into JAM, then reset mid-burst.
    add(3'b001, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    add(3'b011, 3'b000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    add(3'b011, 3'b000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    run_table("pre_reset_jam");
    #2;
    reset = 1'b0;
    #1;
    push_zero();
    compare("reset_in_jam_now", 0);
    @(posedge clk);
    #1;
    push_zero();
    compare("reset_in_jam_held", 0);
    @(negedge clk);
    reset = 1'b1;
    add(3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    add(3'b010, 3'b010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    add(3'b000, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    add_gap(3'b000);
    run_table("after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/hub_arbiter.md
HUB_ARBITER -- requirements
Module: hub_arbiter

Interface
REQ-001 SHALL have parameter JAM_CYCLES, default 4, length of the jam burst in clk cycles (>=1).
REQ-002 SHALL have parameter GAP_CYCLES, default 12, inter-frame gap in clk cycles (>=1).
REQ-003 SHALL have parameter MAX_FRAME, default 1518, jabber limit in bytes (cycles) per grant.
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low (asserted at 0); deassertion is synchronised by the bench to clk.
REQ-006 SHALL have port req  input  3  per-port rx_valid, bit0=port1, bit1=port2, bit2=port3.
REQ-007 SHALL have port grant  output  3  one-hot (or zero) owner of the shared repeat bus.
REQ-008 SHALL have port bus_busy  output  1  high in GRANT, JAM and GAP.
REQ-009 SHALL have port collision  output  1  one-cycle pulse on collision detect.
REQ-010 SHALL have port jabber  output  1  one-cycle pulse when MAX_FRAME exceeded.
REQ-011 SHALL have port jam  output  1  high throughout JAM state.
REQ-012 SHALL have port frame_done  output  1  one-cycle pulse on clean end of granted frame.

Function
REQ-013 SHALL implement states IDLE, GRANT, JAM, GAP; all outputs registered.
REQ-014 SHALL keep per-port armed flag: set while req[i]=0 is sampled; cleared when port i is granted or leaves a collision; only armed ports with req high are eligible.
REQ-015 IDLE: if any eligible port, SHALL select by round-robin starting at (last_grant+1) mod 3, assert grant one cycle after req sampled, record last_grant, enter GRANT.
REQ-016 IDLE with no eligible port SHALL hold grant=0, bus_busy=0.
REQ-017 GRANT: byte counter SHALL clear on entry and increment each cycle req[owner]=1; width sufficient to hold MAX_FRAME without wrap.
REQ-018 GRANT: req[owner] low SHALL end frame: pulse frame_done, clear grant, enter GAP next cycle.
REQ-019 GRANT: any non-owner req high while req[owner] high SHALL pulse collision, clear grant, enter JAM.
REQ-020 Same cycle owner drops and non-owner rises SHALL be treated as clean end (REQ-018), no collision.
REQ-021 GRANT: counter reaching MAX_FRAME with req[owner] still high SHALL pulse jabber, clear grant, enter JAM; jabber takes priority over simultaneous collision (only jabber pulses).
REQ-022 JAM: jam=1 for exactly JAM_CYCLES cycles, req ignored, then GAP.
REQ-023 GAP: grant=0 for exactly GAP_CYCLES cycles, req ignored for arbitration (armed flags still update), then IDLE.
REQ-024 All ports that were requesting at collision/jabber SHALL be disarmed until they sample req low.
REQ-025 last_grant SHALL update only on a new grant; JAM/GAP do not change it.

Reset
REQ-026 On reset=0, immediately: state IDLE, grant=0, bus_busy=0, collision=0, jabber=0, jam=0, frame_done=0, counters 0, armed=3'b000, last_grant=port3 (first grant search starts at port1).
REQ-027 Reset asserted mid-GRANT/JAM/GAP SHALL abort the operation with no pulses emitted.

Verification
REQ-028 req=001 for 13 cycles after idle low -> grant=001 one cycle later for 13 cycles, frame_done pulse, bus_busy low 12 cycles after grant drops.
REQ-029 req=111 simultaneous from IDLE after arming, three sequential frames -> grant order 001, 010, 100.
REQ-030 port1 granted, port3 req rises at byte 5 -> collision pulse, grant=000, jam high 4 cycles, GAP 12, neither port re-granted until its req drops and rises.
REQ-031 port2 holds req 1600 cycles -> jabber pulse at count 1518, jam 4 cycles, no frame_done.
REQ-032 port1 drops req same cycle port2 raises -> frame_done, no collision; port2 granted after GAP.
REQ-033 reset low during JAM -> all outputs 0 same cycle; after release, req=010 armed -> grant=010.
